pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the five-stage core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives every `stall`/`flush` pin on them, plus the PC hold.
- Resolves the load-use hazard, multi-cycle MUL/DIV occupancy, data-memory wait states, branch/jump redirects and trap entry.
- Keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `TRAP_FLUSH_CYCLES`, default 2: cycles IF/ID and ID/EX are flushed after trap entry. Legal range is ≥1.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_id_rs1`, `i_id_rs2` in 5 each: source register indices of the instruction in ID.
- `i_id_rs1_used`, `i_id_rs2_used` in 1 each: the instruction in ID reads that source.
- `i_ex_valid` in 1: EX holds a valid instruction.
- `i_ex_is_load` in 1: the EX instruction is a load.
- `i_ex_rd` in 5: destination register of the EX instruction.
- `i_ex_mdu_start` in 1: a MUL/DIV is in EX this cycle and has started.
- `i_mdu_done` in 1: MDU result valid. This is a level signal, held by the MDU until EX advances.
- `i_mem_req` in 1: MEM stage has an active data-memory access.
- `i_mem_ready` in 1: data memory completes the access this cycle.
- `i_ex_redirect` in 1: taken branch or jump resolved in EX.
- `i_trap` in 1: trap or `mret` committing in MEM/WB.
- `o_pc_stall` out 1: hold PC.
- `o_ifid_stall`, `o_ifid_flush` out 1 each: IF/ID register control.
- `o_idex_stall`, `o_idex_flush` out 1 each: ID/EX register control.
- `o_exmem_stall`, `o_exmem_flush` out 1 each: EX/MEM register control.
- `o_memwb_flush` out 1: MEM/WB register control.
- `o_mdu_kill` out 1: abort the in-flight MUL/DIV.
- `o_state` out 2: FSM state, for debug.
- `o_stall_cnt` out `CNT_W`: stall-cycle counter.

## Operation
FSM states:
- `RUN` = 0
- `MDU_WAIT` = 1
- `TRAP_FLUSH` = 2

Register contents:
- FSM state.
- Trap countdown `tcnt`, width `$clog2(TRAP_FLUSH_CYCLES+1)`.
- `o_stall_cnt`.

All stall/flush outputs are combinational from the state and the current inputs.

Conditions, evaluated each cycle:
- `mem_wait` = `i_mem_req & !i_mem_ready`.
- `mdu_busy` = (`state==MDU_WAIT` | `i_ex_mdu_start`) & `!i_mdu_done`.
- `load_use` = `i_ex_valid & i_ex_is_load & (i_ex_rd!=0)` & ((`i_id_rs1_used & rs1==rd`) | (`i_id_rs2_used & rs2==rd`)).

Priority, highest first; the first matching rule sets all outputs:
1. **`i_trap`**
   - Flush IF/ID, ID/EX and EX/MEM.
   - Assert `o_mdu_kill`.
   - No stalls.
   - Next state is `TRAP_FLUSH`, with `tcnt` = `TRAP_FLUSH_CYCLES`.
2. **`mem_wait`**
   - Stall PC, IF/ID, ID/EX and EX/MEM.
   - Flush MEM/WB, inserting a bubble into WB.
   - The FSM state is unchanged.
3. **`mdu_busy`**
   - Stall PC, IF/ID and ID/EX.
   - Flush EX/MEM.
   - Next state is `MDU_WAIT`.
4. **`state==TRAP_FLUSH`**
   - Flush IF/ID and ID/EX.
   - `i_ex_redirect` and `load_use` are ignored.
   - `tcnt` decrements each cycle.
   - Next state is `RUN` when `tcnt` reaches 1.
5. **`i_ex_redirect`**
   - Flush IF/ID and ID/EX; the PC is not stalled.
   - A redirect overrides `load_use`, because the ID instruction is wrong-path.
6. **`load_use`**
   - Stall PC and IF/ID.
   - Flush ID/EX: one bubble.
7. **Otherwise**: all outputs are 0.

State transitions:
- `MDU_WAIT` returns to `RUN` in the cycle where `i_mdu_done=1` and no higher rule fires. EX/MEM captures the result in that cycle.
- `i_trap` in `TRAP_FLUSH` reloads `tcnt`.
- `i_trap` in `MDU_WAIT` goes to `TRAP_FLUSH`.

Stall counter:
- `o_stall_cnt` increments on every cycle with `o_pc_stall=1`.
- It saturates at all-ones and does not wrap.

## Timing
- Reset (`i_rst_n=0` at a clock edge):
  - `state`=`RUN`, `tcnt`=0, `o_stall_cnt`=0.
  - While `i_rst_n=0`, all stall/flush outputs and `o_mdu_kill` are forced to 0.
- Reset mid-operation abandons `MDU_WAIT` or `TRAP_FLUSH` with no residual effect.
- Outputs have zero-cycle latency from the inputs. There are no combinational paths from the outputs back to the inputs.
- Load-use costs exactly 1 bubble: on the next cycle the load has left EX, so `load_use` deasserts.
- MUL/DIV: from the `i_ex_mdu_start` cycle through the cycle before `i_mdu_done`, PC, IF/ID and ID/EX are stalled.
- Memory wait lasts exactly as long as `i_mem_req & !i_mem_ready`.
- Trap: 1 trap cycle, then `TRAP_FLUSH_CYCLES` flush cycles, then `RUN`.

## Structure
- `pipe_state_e` (the 2-bit enum) and a `pipe_ctrl_t` struct bundling all stall/flush bits go in `cotm32_pipeline_pkg`.
- One sub-module, `hazard_detect`: purely combinational `load_use` compare.
- The FSM, `tcnt` and the counter live in `pipeline_ctrl`.

## Test plan
1. **Load-use**: `lw x5` in EX, `add x6,x5,x1` in ID → 1 cycle with `o_pc_stall=o_ifid_stall=o_idex_flush=1`, then all 0. The same with rd=x0 → no stall.
2. **DIV**: `i_ex_mdu_start` at cycle 0, `i_mdu_done` at cycle 34 → stalls and `o_exmem_flush` on cycles 0–33; cycle 34 all 0, `o_state` returns to 0. `o_stall_cnt`=34.
3. **Memory wait inside DIV**: `i_mem_req=1`, `i_mem_ready=0` for 3 cycles during `MDU_WAIT` → `o_exmem_stall=1`, `o_memwb_flush=1`, and `o_state` stays 1.
4. **Redirect plus load-use in the same cycle** → `o_ifid_flush=o_idex_flush=1` and `o_pc_stall=0`.
5. **`i_trap` during `MDU_WAIT`** → `o_mdu_kill=1` and flushes on IF/ID, ID/EX and EX/MEM, then 2 cycles of IF/ID and ID/EX flush, then `RUN`. `i_ex_redirect` during `TRAP_FLUSH` is ignored.
6. **Counter**: with `CNT_W`=4, hold `mem_wait` for 20 cycles → `o_stall_cnt` saturates at 15. Drop `i_rst_n` mid-stall → next cycle `o_stall_cnt`=0 and `o_state`=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package cotm32_pipeline_pkg;

  // Controller FSM; encodings are visible on o_state for debug
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MDU_WAIT   = 2'd1,
    ST_TRAP_FLUSH = 2'd2
  } pipe_state_e;

  // Every stall/flush pin the controller drives, plus the MDU abort
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_flush;
    logic mdu_kill;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '0;

  // A source operand depends on a destination when it is actually read and the indices match
  function automatic logic reg_match(input logic used, input logic [4:0] src, input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - ID/EX operand bundle for the load-use hazard compare
interface pipeline_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       load_use;

  // master supplies the operand fields and consumes the verdict
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_rd,
    input  load_use
  );

  // slave is the comparator
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_rd,
    output load_use
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use dependency compare
module hazard_detect
  import cotm32_pipeline_pkg::*;
(
  pipeline_ctrl_if.slave hz
);

  // A load in EX writing a non-zero register that ID reads forces one bubble
  assign hz.load_use = hz.ex_valid & hz.ex_is_load & (hz.ex_rd != 5'd0) &
                       (reg_match(hz.id_rs1_used, hz.id_rs1, hz.ex_rd) |
                        reg_match(hz.id_rs2_used, hz.id_rs2, hz.ex_rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central stall/flush sequencer for the five-stage core
module pipeline_ctrl
  import cotm32_pipeline_pkg::*;
#(
  parameter int TRAP_FLUSH_CYCLES = 2,
  parameter int CNT_W             = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mdu_start,
  input  logic             i_mdu_done,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_ex_redirect,
  input  logic             i_trap,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic             o_mdu_kill,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int                TCNT_W    = $clog2(TRAP_FLUSH_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TRAP_FLUSH_CYCLES);

  pipe_state_e       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  pipe_ctrl_t        ctrl;
  logic              mem_wait;
  logic              mdu_busy;
  logic              load_use;

  pipeline_ctrl_if hz_if ();

  assign hz_if.id_rs1      = i_id_rs1;
  assign hz_if.id_rs2      = i_id_rs2;
  assign hz_if.id_rs1_used = i_id_rs1_used;
  assign hz_if.id_rs2_used = i_id_rs2_used;
  assign hz_if.ex_valid    = i_ex_valid;
  assign hz_if.ex_is_load  = i_ex_is_load;
  assign hz_if.ex_rd       = i_ex_rd;

  hazard_detect u_hazard_detect (
    .hz (hz_if.slave)
  );

  assign load_use = hz_if.load_use;
  assign mem_wait = i_mem_req & ~i_mem_ready;
  // The MDU holds done high until EX advances, so done alone ends the occupancy
  assign mdu_busy = ((state_q == ST_MDU_WAIT) | i_ex_mdu_start) & ~i_mdu_done;

  // Priority resolution: the first matching hazard sets every control bit and the next state
  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = state_q;
    tcnt_d  = tcnt_q;
    if (i_trap) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      ctrl.mdu_kill    = 1'b1;
      state_d          = ST_TRAP_FLUSH;
      tcnt_d           = TCNT_LOAD;
    end else if (mem_wait) begin
      // Freeze everything upstream of MEM and feed WB a bubble; FSM and tcnt hold
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (mdu_busy) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      state_d          = ST_MDU_WAIT;
      tcnt_d           = '0;
    end else if (state_q == ST_TRAP_FLUSH) begin
      // Wrong-path fetches after a trap are discarded; redirect and load-use are moot here
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      tcnt_d           = tcnt_q - TCNT_W'(1);
      state_d          = (tcnt_q <= TCNT_W'(1)) ? ST_RUN : ST_TRAP_FLUSH;
    end else begin
      state_d = ST_RUN;
      if (i_ex_redirect) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_stall   = 1'b1;
        ctrl.ifid_stall = 1'b1;
        ctrl.idex_flush = 1'b1;
      end
    end
    if (!i_rst_n) begin
      ctrl = CTRL_IDLE;
    end
  end

  // Saturating count of PC-hold cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, trap countdown and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      tcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_pc_stall    = ctrl.pc_stall;
  assign o_ifid_stall  = ctrl.ifid_stall;
  assign o_ifid_flush  = ctrl.ifid_flush;
  assign o_idex_stall  = ctrl.idex_stall;
  assign o_idex_flush  = ctrl.idex_flush;
  assign o_exmem_stall = ctrl.exmem_stall;
  assign o_exmem_flush = ctrl.exmem_flush;
  assign o_memwb_flush = ctrl.memwb_flush;
  assign o_mdu_kill    = ctrl.mdu_kill;
  assign o_state       = state_q;
  assign o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int TFC = 2;

  localparam logic [8:0] B_PC   = 9'h100;
  localparam logic [8:0] B_IFS  = 9'h080;
  localparam logic [8:0] B_IFF  = 9'h040;
  localparam logic [8:0] B_IDS  = 9'h020;
  localparam logic [8:0] B_IDF  = 9'h010;
  localparam logic [8:0] B_EXS  = 9'h008;
  localparam logic [8:0] B_EXF  = 9'h004;
  localparam logic [8:0] B_WBF  = 9'h002;
  localparam logic [8:0] B_KILL = 9'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mdu_start, mdu_done, mem_req, mem_ready, redirect, trap;

  pipeline_ctrl_if stim ();

  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, exmem_flush, memwb_flush, mdu_kill;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic        pc_stall4, ifid_stall4, ifid_flush4, idex_stall4, idex_flush4;
  logic        exmem_stall4, exmem_flush4, memwb_flush4, mdu_kill4;
  logic [1:0]  state4;
  logic [3:0]  cnt4;

  logic [8:0] ctrl_obs, ctrl4_obs;
  assign ctrl_obs  = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                      exmem_stall, exmem_flush, memwb_flush, mdu_kill};
  assign ctrl4_obs = {pc_stall4, ifid_stall4, ifid_flush4, idex_stall4, idex_flush4,
                      exmem_stall4, exmem_flush4, memwb_flush4, mdu_kill4};

  pipeline_ctrl #(.TRAP_FLUSH_CYCLES(TFC), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(stim.id_rs1), .i_id_rs2(stim.id_rs2),
    .i_id_rs1_used(stim.id_rs1_used), .i_id_rs2_used(stim.id_rs2_used),
    .i_ex_valid(stim.ex_valid), .i_ex_is_load(stim.ex_is_load), .i_ex_rd(stim.ex_rd),
    .i_ex_mdu_start(mdu_start), .i_mdu_done(mdu_done),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .i_ex_redirect(redirect), .i_trap(trap),
    .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
    .o_idex_stall(idex_stall), .o_idex_flush(idex_flush),
    .o_exmem_stall(exmem_stall), .o_exmem_flush(exmem_flush),
    .o_memwb_flush(memwb_flush), .o_mdu_kill(mdu_kill),
    .o_state(state), .o_stall_cnt(cnt)
  );

  pipeline_ctrl #(.TRAP_FLUSH_CYCLES(TFC), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(stim.id_rs1), .i_id_rs2(stim.id_rs2),
    .i_id_rs1_used(stim.id_rs1_used), .i_id_rs2_used(stim.id_rs2_used),
    .i_ex_valid(stim.ex_valid), .i_ex_is_load(stim.ex_is_load), .i_ex_rd(stim.ex_rd),
    .i_ex_mdu_start(mdu_start), .i_mdu_done(mdu_done),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .i_ex_redirect(redirect), .i_trap(trap),
    .o_pc_stall(pc_stall4), .o_ifid_stall(ifid_stall4), .o_ifid_flush(ifid_flush4),
    .o_idex_stall(idex_stall4), .o_idex_flush(idex_flush4),
    .o_exmem_stall(exmem_stall4), .o_exmem_flush(exmem_flush4),
    .o_memwb_flush(memwb_flush4), .o_mdu_kill(mdu_kill4),
    .o_state(state4), .o_stall_cnt(cnt4)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 running, 1 waiting on MDU, 2 draining after a trap
  int         m_mode, m_left, n_mode, n_left;
  longint     m_cnt;
  int         m_cnt4;
  logic [8:0] exp_ctrl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit waiting_mem, mdu_occupied, dep;
    waiting_mem  = mem_req && !mem_ready;
    mdu_occupied = (m_mode == 1 || mdu_start) && !mdu_done;
    dep = stim.ex_valid && stim.ex_is_load && stim.ex_rd != 0 &&
          ((stim.id_rs1_used && stim.id_rs1 == stim.ex_rd) ||
           (stim.id_rs2_used && stim.id_rs2 == stim.ex_rd));
    stim.load_use = dep;
    n_mode = m_mode;
    n_left = m_left;
    exp_ctrl = '0;
    if (trap) begin
      exp_ctrl = B_IFF | B_IDF | B_EXF | B_KILL;
      n_mode = 2; n_left = TFC;
    end else if (waiting_mem) begin
      exp_ctrl = B_PC | B_IFS | B_IDS | B_EXS | B_WBF;
    end else if (mdu_occupied) begin
      exp_ctrl = B_PC | B_IFS | B_IDS | B_EXF;
      n_mode = 1;
    end else if (m_mode == 2) begin
      exp_ctrl = B_IFF | B_IDF;
      n_left = m_left - 1;
      n_mode = (n_left == 0) ? 0 : 2;
    end else begin
      n_mode = 0;
      if (redirect)  exp_ctrl = B_IFF | B_IDF;
      else if (dep)  exp_ctrl = B_PC | B_IFS | B_IDF;
    end
    if (!rst_n) exp_ctrl = '0;
  endtask

  task automatic model_seq();
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_mode = n_mode;
      m_left = n_left;
      if ((exp_ctrl & B_PC) != 0) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
  endtask

  // One clock: check outputs against the model, take the edge, advance the model
  task automatic cycle();
    #1;
    model_comb();
    check("ctrl", {55'd0, ctrl_obs}, {55'd0, exp_ctrl});
    check("ctrl4", {55'd0, ctrl4_obs}, {55'd0, exp_ctrl});
    check("state", {62'd0, state}, 64'(m_mode));
    check("state4", {62'd0, state4}, 64'(m_mode));
    check("cnt", {32'd0, cnt}, 64'(m_cnt));
    check("cnt4", {60'd0, cnt4}, 64'(m_cnt4));
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic idle();
    stim.id_rs1 = 5'd0; stim.id_rs2 = 5'd0;
    stim.id_rs1_used = 1'b0; stim.id_rs2_used = 1'b0;
    stim.ex_valid = 1'b0; stim.ex_is_load = 1'b0; stim.ex_rd = 5'd0;
    stim.load_use = 1'b0;
    mdu_start = 1'b0; mdu_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    redirect = 1'b0; trap = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use();
    stim.ex_valid = 1'b1; stim.ex_is_load = 1'b1; stim.ex_rd = 5'd5;
    stim.id_rs1 = 5'd5; stim.id_rs1_used = 1'b1;
    stim.id_rs2 = 5'd1; stim.id_rs2_used = 1'b1;
  endtask

  initial begin
    m_mode = 0; m_left = 0; m_cnt = 0; m_cnt4 = 0;
    n_mode = 0; n_left = 0; exp_ctrl = '0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_cnt", {32'd0, cnt}, 64'd0);
    check("rst_ctrl", {55'd0, ctrl_obs}, 64'd0);

    // Load-use: one bubble, then clear; rd=x0 never stalls
    do_reset();
    set_load_use();
    #1 check("lu_bubble", {55'd0, ctrl_obs}, {55'd0, B_PC | B_IFS | B_IDF});
    cycle();
    stim.ex_is_load = 1'b0;
    #1 check("lu_after", {55'd0, ctrl_obs}, 64'd0);
    cycle();
    set_load_use();
    stim.ex_rd = 5'd0; stim.id_rs1 = 5'd0;
    #1 check("lu_x0", {55'd0, ctrl_obs}, 64'd0);
    cycle();

    // DIV: start at cycle 0, done at cycle 34
    do_reset();
    mdu_start = 1'b1;
    for (int i = 0; i < 34; i++) begin
      #1 check("div_ctrl", {55'd0, ctrl_obs}, {55'd0, B_PC | B_IFS | B_IDS | B_EXF});
      cycle();
      mdu_start = 1'b0;
    end
    check("div_state_wait", {62'd0, state}, 64'd1);
    mdu_done = 1'b1;
    #1 check("div_done_ctrl", {55'd0, ctrl_obs}, 64'd0);
    cycle();
    mdu_done = 1'b0;
    check("div_state_run", {62'd0, state}, 64'd0);
    check("div_cnt", {32'd0, cnt}, 64'd34);

    // Memory wait inside an MDU wait
    do_reset();
    mdu_start = 1'b1;
    cycle();
    mdu_start = 1'b0;
    cycle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("memdiv_ctrl", {55'd0, ctrl_obs}, {55'd0, B_PC | B_IFS | B_IDS | B_EXS | B_WBF});
      check("memdiv_state", {62'd0, state}, 64'd1);
      cycle();
    end
    mem_req = 1'b0; mdu_done = 1'b1;
    cycle();
    mdu_done = 1'b0;
    check("memdiv_end_state", {62'd0, state}, 64'd0);
    check("memdiv_cnt", {32'd0, cnt}, 64'd5);

    // Redirect beats load-use
    do_reset();
    set_load_use();
    redirect = 1'b1;
    #1 check("redir_lu", {55'd0, ctrl_obs}, {55'd0, B_IFF | B_IDF});
    cycle();
    idle();

    // Trap during MDU wait, redirect ignored while draining
    do_reset();
    mdu_start = 1'b1;
    cycle();
    mdu_start = 1'b0;
    cycle();
    trap = 1'b1;
    #1 check("trap_ctrl", {55'd0, ctrl_obs}, {55'd0, B_IFF | B_IDF | B_EXF | B_KILL});
    cycle();
    trap = 1'b0; redirect = 1'b1;
    set_load_use();
    for (int i = 0; i < TFC; i++) begin
      #1 check("tflush_ctrl", {55'd0, ctrl_obs}, {55'd0, B_IFF | B_IDF});
      check("tflush_state", {62'd0, state}, 64'd2);
      cycle();
    end
    idle();
    #1 check("trap_run_state", {62'd0, state}, 64'd0);
    check("trap_run_ctrl", {55'd0, ctrl_obs}, 64'd0);
    cycle();

    // Counter saturation in the 4-bit instance, then reset mid-stall
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_cnt4", {60'd0, cnt4}, 64'd15);
    check("sat_cnt32", {32'd0, cnt}, 64'd20);
    rst_n = 1'b0;
    #1 check("rst_forces_zero", {55'd0, ctrl4_obs}, 64'd0);
    cycle();
    rst_n = 1'b1;
    check("rst_mid_cnt4", {60'd0, cnt4}, 64'd0);
    check("rst_mid_state4", {62'd0, state4}, 64'd0);
    idle();

    // Random stimulus against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      stim.id_rs1      = 5'($urandom_range(0, 3));
      stim.id_rs2      = 5'($urandom_range(0, 3));
      stim.id_rs1_used = 1'($urandom_range(0, 1));
      stim.id_rs2_used = 1'($urandom_range(0, 1));
      stim.ex_valid    = 1'($urandom_range(0, 1));
      stim.ex_is_load  = 1'($urandom_range(0, 1));
      stim.ex_rd       = 5'($urandom_range(0, 3));
      mdu_start = ($urandom_range(0, 7) == 0);
      mdu_done  = ($urandom_range(0, 3) == 0);
      mem_req   = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 2) != 0);
      redirect  = ($urandom_range(0, 4) == 0);
      trap      = ($urandom_range(0, 24) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
